// File: rtl/x_top_bus_arb_pkg.sv
// Shared types and helpers for the x_top bus arbiter: FSM states, abort data, grant width.
package x_top_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Read data a master sees when its slave access is aborted by the watchdog.
   localparam logic [31:0] c_err_data = 32'hDEADBEEF;

   // Width of a master index; a single master still needs one bit.
   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/x_top_bus_arb_if.sv
// Bus bundle between N requesting masters, the arbiter and the shared slave.
// The arbiter takes the slave modport; whatever drives the masters and the slave takes master.
interface x_top_bus_arb_if
   import x_top_pkg::*;
#(
   parameter int p_masters = 2,
   parameter int p_addr_w  = 32,
   parameter int p_data_w  = 32
);
   localparam int lp_gw = grant_w(p_masters);

   logic [p_masters-1:0]          i_m_valid;
   logic [p_masters-1:0]          i_m_rnw;
   logic [p_masters*p_addr_w-1:0] i_m_addr;
   logic [p_masters*p_data_w-1:0] i_m_data;
   logic [p_masters-1:0]          o_m_accept;
   logic [p_masters-1:0]          o_m_err;
   logic [p_data_w-1:0]           o_m_data;

   logic                          o_s_valid;
   logic                          o_s_rnw;
   logic [p_addr_w-1:0]           o_s_addr;
   logic [p_data_w-1:0]           o_s_data;
   logic                          i_s_accept;
   logic [p_data_w-1:0]           i_s_data;

   logic [lp_gw-1:0]              o_grant;

   modport slave (
      input  i_m_valid, i_m_rnw, i_m_addr, i_m_data, i_s_accept, i_s_data,
      output o_m_accept, o_m_err, o_m_data, o_s_valid, o_s_rnw, o_s_addr, o_s_data, o_grant
   );

   modport master (
      output i_m_valid, i_m_rnw, i_m_addr, i_m_data, i_s_accept, i_s_data,
      input  o_m_accept, o_m_err, o_m_data, o_s_valid, o_s_rnw, o_s_addr, o_s_data, o_grant
   );

endinterface

// File: rtl/x_top_bus_arb_rr_arb.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping to 0.
module x_top_rr_arb #(
   parameter int p_masters = 2,
   parameter int p_gw      = 1
) (
   input  logic [p_masters-1:0] req_i,
   input  logic [p_gw-1:0]      last_i,
   output logic [p_gw-1:0]      win_o,
   output logic                 any_o
);

   logic found;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      win_o = '0;
      found = 1'b0;
      // Upper segment (above the last winner) has priority over the wrapped lower segment.
      for (int i = 0; i < p_masters; i++) begin
         if (!found && req_i[i] && (i > int'(last_i))) begin
            found = 1'b1;
            win_o = p_gw'(i);
         end
      end
      for (int i = 0; i < p_masters; i++) begin
         if (!found && req_i[i] && (i <= int'(last_i))) begin
            found = 1'b1;
            win_o = p_gw'(i);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/x_top_bus_arb.sv
// N-master to 1-slave round-robin arbiter for the valid/accept memory bus.
// One transaction in flight; an optional watchdog aborts slave accesses that never complete.
module x_top_bus_arb
   import x_top_pkg::*;
#(
   parameter int          p_masters  = 2,
   parameter int          p_addr_w   = 32,
   parameter int          p_data_w   = 32,
   parameter int          p_timeout  = 0,
   parameter logic [31:0] p_err_data = c_err_data
) (
   input logic            i_clk,
   input logic            i_nrst,
   x_top_bus_arb_if.slave bus
);

   localparam int lp_gw   = grant_w(p_masters);
   localparam int lp_wd_w = (p_timeout > 1) ? $clog2(p_timeout) : 1;

   state_e                 state_q,    state_d;
   logic [lp_gw-1:0]       last_q,     last_d;
   logic [lp_gw-1:0]       grant_q,    grant_d;
   logic                   s_valid_q,  s_valid_d;
   logic                   s_rnw_q,    s_rnw_d;
   logic [p_addr_w-1:0]    s_addr_q,   s_addr_d;
   logic [p_data_w-1:0]    s_data_q,   s_data_d;
   logic [p_data_w-1:0]    m_data_q,   m_data_d;
   logic [p_masters-1:0]   m_accept_q, m_accept_d;
   logic [p_masters-1:0]   m_err_q,    m_err_d;
   logic [lp_wd_w-1:0]     wdog_q,     wdog_d;

   logic [lp_gw-1:0]       win;
   logic                   any_req;
   logic                   wd_expired;

   x_top_rr_arb #(
      .p_masters (p_masters),
      .p_gw      (lp_gw)
   ) u_rr_arb (
      .req_i  (bus.i_m_valid),
      .last_i (last_q),
      .win_o  (win),
      .any_o  (any_req)
   );

   assign wd_expired = (p_timeout != 0) && (int'(wdog_q) == p_timeout - 1);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      s_valid_d  = s_valid_q;
      s_rnw_d    = s_rnw_q;
      s_addr_d   = s_addr_q;
      s_data_d   = s_data_q;
      m_data_d   = m_data_q;
      wdog_d     = wdog_q;
      m_accept_d = '0;
      m_err_d    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d   = win;
               s_valid_d = 1'b1;
               s_rnw_d   = bus.i_m_rnw[win];
               s_addr_d  = bus.i_m_addr[int'(win)*p_addr_w +: p_addr_w];
               s_data_d  = bus.i_m_data[int'(win)*p_data_w +: p_data_w];
               wdog_d    = '0;
               state_d   = ST_REQ;
            end
         end
         ST_REQ: begin
            // A slave accept on the expiry cycle still completes normally.
            if (bus.i_s_accept) begin
               m_data_d            = bus.i_s_data;
               s_valid_d           = 1'b0;
               m_accept_d[grant_q] = 1'b1;
               state_d             = ST_RESP;
            end else if (wd_expired) begin
               m_data_d            = p_data_w'(p_err_data);
               s_valid_d           = 1'b0;
               m_accept_d[grant_q] = 1'b1;
               m_err_d[grant_q]    = 1'b1;
               state_d             = ST_RESP;
            end else begin
               wdog_d = wdog_q + lp_wd_w'(1);
            end
         end
         ST_RESP: begin
            // No arbitration here: the completing master's valid is still high this cycle.
            last_d  = grant_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q    <= ST_IDLE;
         last_q     <= lp_gw'(p_masters - 1);
         grant_q    <= '0;
         s_valid_q  <= 1'b0;
         s_rnw_q    <= 1'b0;
         s_addr_q   <= '0;
         s_data_q   <= '0;
         m_data_q   <= '0;
         m_accept_q <= '0;
         m_err_q    <= '0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         s_valid_q  <= s_valid_d;
         s_rnw_q    <= s_rnw_d;
         s_addr_q   <= s_addr_d;
         s_data_q   <= s_data_d;
         m_data_q   <= m_data_d;
         m_accept_q <= m_accept_d;
         m_err_q    <= m_err_d;
         wdog_q     <= wdog_d;
      end
   end

   assign bus.o_s_valid  = s_valid_q;
   assign bus.o_s_rnw    = s_rnw_q;
   assign bus.o_s_addr   = s_addr_q;
   assign bus.o_s_data   = s_data_q;
   assign bus.o_m_data   = m_data_q;
   assign bus.o_m_accept = m_accept_q;
   assign bus.o_m_err    = m_err_q;
   assign bus.o_grant    = grant_q;

endmodule

// File: tb/tb_x_top_bus_arb.sv
// Directed bench for x_top_bus_arb: a 2-master instance with an 8-cycle watchdog and a
// 4-master instance without one; completions are checked against a scoreboard queue.
module tb_x_top_bus_arb;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   x_top_bus_arb_if #(.p_masters(2), .p_addr_w(32), .p_data_w(32)) bus2 ();
   x_top_bus_arb_if #(.p_masters(4), .p_addr_w(32), .p_data_w(32)) bus4 ();

   x_top_bus_arb #(
      .p_masters (2), .p_addr_w (32), .p_data_w (32),
      .p_timeout (8), .p_err_data (32'hDEADBEEF)
   ) dut2 (
      .i_clk (clk), .i_nrst (rst_n), .bus (bus2)
   );

   x_top_bus_arb #(
      .p_masters (4), .p_addr_w (32), .p_data_w (32),
      .p_timeout (0), .p_err_data (32'hDEADBEEF)
   ) dut4 (
      .i_clk (clk), .i_nrst (rst_n), .bus (bus4)
   );

   typedef struct {
      int          master;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int m, input logic [31:0] d, input logic e);
      exp_t x;
      x.master = m;
      x.data   = d;
      x.err    = e;
      sb_q.push_back(x);
   endtask

   task automatic sb_compare(input string tag, input logic [3:0] acc, input logic [3:0] err,
                             input logic [31:0] data);
      exp_t       e;
      logic [3:0] oh;
      check({tag, "_pending"}, 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         oh = 4'b0001 << e.master;
         check({tag, "_accept"}, 64'(acc), 64'(oh));
         check({tag, "_err"}, 64'(err), e.err ? 64'(oh) : 64'd0);
         check({tag, "_data"}, 64'(data), 64'(e.data));
      end
   endtask

   task automatic wait_svalid2(output int n);
      n = 0;
      while (bus2.o_s_valid !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      check("svalid2_seen", 64'(bus2.o_s_valid), 64'd1);
   endtask

   task automatic wait_svalid4(output int n);
      n = 0;
      while (bus4.o_s_valid !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      check("svalid4_seen", 64'(bus4.o_s_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL tb_timeout: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      int          n;
      int          g;
      logic [31:0] d;

      rst_n = 1'b0;
      bus2.i_m_valid = '0; bus2.i_m_rnw = '0; bus2.i_m_addr = '0; bus2.i_m_data = '0;
      bus2.i_s_accept = 1'b0; bus2.i_s_data = '0;
      bus4.i_m_valid = '0; bus4.i_m_rnw = '0; bus4.i_m_addr = '0; bus4.i_m_data = '0;
      bus4.i_s_accept = 1'b0; bus4.i_s_data = '0;
      repeat (3) step();

      // Reset state
      check("rst2_ctrl", {bus2.o_s_valid, bus2.o_m_accept, bus2.o_m_err, bus2.o_grant}, 0);
      check("rst2_data", {bus2.o_m_data, bus2.o_s_addr}, 0);
      check("rst4_ctrl", {bus4.o_s_valid, bus4.o_m_accept, bus4.o_m_err, bus4.o_grant}, 0);
      rst_n = 1'b1;
      step();

      // Master 1 write, slave accepts on the 4th REQ cycle
      bus2.i_m_valid = 2'b10;
      bus2.i_m_rnw   = 2'b00;
      bus2.i_m_addr  = {32'h0000_0100, 32'h0};
      bus2.i_m_data  = {32'hCAFE_F00D, 32'h0};
      step();
      check("t1_svalid", bus2.o_s_valid, 1);
      check("t1_addr", bus2.o_s_addr, 64'h100);
      check("t1_rnw", bus2.o_s_rnw, 0);
      check("t1_wdata", bus2.o_s_data, 64'hCAFEF00D);
      check("t1_grant", bus2.o_grant, 1);
      repeat (3) step();
      check("t1_no_early_accept", bus2.o_m_accept, 0);
      bus2.i_s_accept = 1'b1;
      bus2.i_s_data   = 32'h1111_2222;
      push(1, 32'h1111_2222, 1'b0);
      step();
      bus2.i_s_accept = 1'b0;
      bus2.i_m_valid  = 2'b00;
      sb_compare("t1", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      check("t1_svalid_drop", bus2.o_s_valid, 0);
      step();
      check("t1_single_pulse", bus2.o_m_accept, 0);

      // Both masters reading continuously, immediate slave accept
      bus2.i_m_valid = 2'b11;
      bus2.i_m_rnw   = 2'b11;
      bus2.i_m_addr  = {32'h0000_0020, 32'h0000_0010};
      for (int k = 0; k < 4; k++) begin
         wait_svalid2(n);
         if (k > 0) check("t2_period", n, 2);
         check("t2_grant", bus2.o_grant, k % 2);
         check("t2_addr", bus2.o_s_addr, (k % 2 == 0) ? 64'h10 : 64'h20);
         check("t2_rnw", bus2.o_s_rnw, 1);
         d = 32'hA500_0000 + 32'(k);
         bus2.i_s_accept = 1'b1;
         bus2.i_s_data   = d;
         push(k % 2, d, 1'b0);
         step();
         bus2.i_s_accept = 1'b0;
         if (k == 3) bus2.i_m_valid = 2'b00;
         sb_compare("t2", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      end
      step();

      // Watchdog abort: slave never accepts
      bus2.i_m_valid = 2'b01;
      bus2.i_m_rnw   = 2'b01;
      bus2.i_m_addr  = {32'h0, 32'h0000_0300};
      push(0, 32'hDEAD_BEEF, 1'b1);
      wait_svalid2(n);
      check("t3_grant", bus2.o_grant, 0);
      n = 0;
      while (bus2.o_s_valid === 1'b1 && n < 20) begin
         n++;
         step();
      end
      check("t3_req_cycles", n, 8);
      bus2.i_m_valid = 2'b00;
      sb_compare("t3", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      step();
      check("t3_err_single", bus2.o_m_err, 0);

      // Next request after an abort proceeds normally
      bus2.i_m_valid = 2'b10;
      bus2.i_m_rnw   = 2'b00;
      bus2.i_m_addr  = {32'h0000_0400, 32'h0};
      bus2.i_m_data  = {32'h1234_5678, 32'h0};
      wait_svalid2(n);
      check("t3b_grant", bus2.o_grant, 1);
      check("t3b_wdata", bus2.o_s_data, 64'h12345678);
      bus2.i_s_accept = 1'b1;
      bus2.i_s_data   = 32'h55AA_55AA;
      push(1, 32'h55AA_55AA, 1'b0);
      step();
      bus2.i_s_accept = 1'b0;
      bus2.i_m_valid  = 2'b00;
      sb_compare("t3b", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      step();

      // Slave accept on the exact expiry cycle wins over the abort
      bus2.i_m_valid = 2'b01;
      bus2.i_m_rnw   = 2'b01;
      bus2.i_m_addr  = {32'h0, 32'h0000_0500};
      wait_svalid2(n);
      repeat (7) step();
      check("t4_svalid_at_expiry", bus2.o_s_valid, 1);
      bus2.i_s_accept = 1'b1;
      bus2.i_s_data   = 32'h0BAD_C0DE;
      push(0, 32'h0BAD_C0DE, 1'b0);
      step();
      bus2.i_s_accept = 1'b0;
      bus2.i_m_valid  = 2'b00;
      sb_compare("t4", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      step();

      // Reset during REQ: no accept, pointer back to master 0 first
      bus2.i_m_valid = 2'b11;
      bus2.i_m_rnw   = 2'b11;
      bus2.i_m_addr  = {32'h0000_0700, 32'h0000_0600};
      wait_svalid2(n);
      check("t5_grant_before", bus2.o_grant, 1);
      rst_n = 1'b0;
      step();
      check("t5_rst_ctrl", {bus2.o_s_valid, bus2.o_m_accept, bus2.o_m_err, bus2.o_grant}, 0);
      check("t5_rst_data", {bus2.o_m_data, bus2.o_s_addr}, 0);
      rst_n = 1'b1;
      wait_svalid2(n);
      check("t5_restart_latency", n, 1);
      check("t5_grant_after", bus2.o_grant, 0);
      check("t5_addr_after", bus2.o_s_addr, 64'h600);
      bus2.i_s_accept = 1'b1;
      bus2.i_s_data   = 32'h600D_600D;
      push(0, 32'h600D_600D, 1'b0);
      step();
      bus2.i_s_accept = 1'b0;
      bus2.i_m_valid  = 2'b00;
      sb_compare("t5", {2'b00, bus2.o_m_accept}, {2'b00, bus2.o_m_err}, bus2.o_m_data);
      step();

      // Four masters, only 1 and 3 requesting
      bus4.i_m_valid = 4'b1010;
      bus4.i_m_rnw   = 4'b1111;
      bus4.i_m_addr  = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
      for (int k = 0; k < 4; k++) begin
         g = (k % 2 == 0) ? 1 : 3;
         wait_svalid4(n);
         if (k > 0) check("t6_period", n, 2);
         check("t6_grant", bus4.o_grant, g);
         check("t6_addr", bus4.o_s_addr, 64'(g * 32'h1000));
         d = 32'hC400_0000 + 32'(k);
         bus4.i_s_accept = 1'b1;
         bus4.i_s_data   = d;
         push(g, d, 1'b0);
         step();
         bus4.i_s_accept = 1'b0;
         if (k == 3) bus4.i_m_valid = 4'b0000;
         sb_compare("t6", bus4.o_m_accept, bus4.o_m_err, bus4.o_m_data);
      end
      step();

      check("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/x_top_bus_arb.md
Name: x_top_bus_arb

Overview:
- Parametrised N-master to 1-slave arbiter for the core/memory valid–accept bus. It lets several x_top_rv32i-class masters (cores, a debug/DMA master) share one x_top_mem-class slave.
- Masters are granted round-robin. Each granted transaction is captured into registers, forwarded to the slave, and completed back to the owning master with read data.
- An optional watchdog aborts transactions the slave never accepts, so one hung access cannot lock the bus.

Parameters:
- p_masters, 2, number of masters (≥1)
- p_addr_w, 32, address width
- p_data_w, 32, data width
- p_timeout, 0, slave-accept watchdog in cycles; 0 disables it
- p_err_data, 32'hDEADBEEF, read data returned on timeout abort (truncated to p_data_w)

Ports:
- i_clk  in  1  clock
- i_nrst  in  1  reset, synchronous, active-low
- i_m_valid  in  p_masters  per-master request
- i_m_rnw  in  p_masters  per-master read(1)/write(0)
- i_m_addr  in  p_masters*p_addr_w  packed addresses; master k occupies bits [k*p_addr_w +: p_addr_w]
- i_m_data  in  p_masters*p_data_w  packed write data
- o_m_accept  out  p_masters  one-hot completion pulse
- o_m_err  out  p_masters  one-hot timeout-abort pulse, coincident with o_m_accept
- o_m_data  out  p_data_w  read data, broadcast to all masters; valid only with accept
- o_s_valid  out  1  slave request
- o_s_rnw  out  1  slave read/write
- o_s_addr  out  p_addr_w  slave address
- o_s_data  out  p_data_w  slave write data
- i_s_accept  in  1  slave completion pulse
- i_s_data  in  p_data_w  slave read data, sampled with i_s_accept
- o_grant  out  max(1,$clog2(p_masters))  index of the current/last granted master

Behaviour:
- Bus protocol: a master holds valid/rnw/addr/data stable until it sees accept, and may drop valid the cycle after. Accept is a single-cycle pulse.
- Reset (i_nrst=0 at a clock edge):
  - state=IDLE; all outputs 0.
  - Round-robin pointer last=p_masters-1, so master 0 wins first.
  - Watchdog counter = 0.
  - Reset mid-transaction drops the transaction with no accept to the master; o_s_valid falls on the next edge.
- FSM states IDLE, REQ, RESP:
  - IDLE: if |i_m_valid, pick a winner, capture its rnw/addr/data into the o_s_* registers, set o_grant, assert o_s_valid, clear the watchdog, go to REQ. Otherwise stay.
  - REQ: o_s_valid=1 with fields held.
    - If i_s_accept: capture i_s_data into o_m_data, drop o_s_valid, go to RESP.
    - Else if p_timeout≠0 and watchdog==p_timeout-1: drop o_s_valid, load p_err_data into o_m_data, set the error flag, go to RESP.
    - Else the watchdog increments.
  - RESP: o_m_accept[o_grant]=1 for exactly one cycle, plus o_m_err[o_grant] if aborted. Set last=o_grant and go to IDLE. No arbitration happens in this cycle, so the completing master's still-high valid is never re-granted.
- Round-robin pick: the first asserted i_m_valid searching from (last+1) mod p_masters upward, with wrap-around.
- Latency:
  - Request seen in IDLE at cycle 0 gives o_s_valid in cycle 1.
  - i_s_accept in cycle n gives o_m_accept in cycle n+1.
  - Minimum 3 cycles per transaction; back-to-back grants start the cycle after RESP.
- Simultaneous events:
  - i_s_accept in the same cycle as watchdog expiry: accept wins, no error.
  - i_s_accept outside REQ: ignored.
- A master dropping valid while in REQ is a protocol violation. The captured copy still completes and the accept pulse is still issued.
- Write transactions: o_m_data carries the slave's i_s_data unmodified.
- p_masters=1: the pick is always 0; o_grant is 1 bit, constant 0.
- o_m_accept and o_m_err are registered, one-hot or zero, never multi-hot.

Decomposition:
- Shared package x_top_pkg holds:
  - state enum (IDLE/REQ/RESP)
  - default error data constant
  - grant-width helper function
- One sub-module, x_top_rr_arb: combinational round-robin picker with inputs request vector and last pointer, outputs winner index and any-valid.

Test Plan:
- Single master 1 writes addr 0x100, data 0xCAFEF00D; slave accepts after 4 cycles → o_s_addr=0x100 and o_s_rnw=0 in the cycle after the request; o_m_accept=2'b10 exactly one cycle after i_s_accept; o_m_err=0.
- Both masters continuously valid with reads, slave accepts immediately → grants alternate 0,1,0,1; each o_m_data equals the i_s_data of its own transaction; period 3 cycles.
- p_timeout=8, master 0 read, slave never accepts → o_s_valid drops after 8 REQ cycles; o_m_accept[0]=o_m_err[0]=1 with o_m_data=0xDEADBEEF; next request proceeds normally.
- p_timeout=8, i_s_accept on the exact expiry cycle → normal completion, o_m_err=0, o_m_data=i_s_data.
- Reset asserted while in REQ → next cycle all outputs 0; no accept issued; after release master 0 wins against master 1 on simultaneous requests.
- p_masters=4, requests on masters 1 and 3 only, last=3 → order 1,3,1,3; masters 0 and 2 never accepted.
